// File: rtl/pe256_sched.sv
// Request scheduler for 256 sticky requesters: grants one at a time, highest index first,
// over a valid/ack handshake with a per-grant timeout. Includes the 256-input priority encoder.

module pe256_from_64 (
   input  logic [255:0] d,
   output logic [7:0]   q,
   output logic         v
);

   logic [3:0] grp_v;
   logic [5:0] grp_q [4];

   // Four 64-bit slices are encoded independently; the highest non-empty slice supplies the index.
   always_comb begin
      q = 8'd0;
      for (int g = 0; g < 4; g++) begin
         grp_v[g] = |d[g*64 +: 64];
         grp_q[g] = 6'd0;
         for (int i = 0; i < 64; i++) begin
            if (d[g*64 + i]) grp_q[g] = 6'(i);
         end
      end
      for (int g = 0; g < 4; g++) begin
         if (grp_v[g]) q = {2'(g), grp_q[g]};
      end
      v = |grp_v;
   end

endmodule

module pe256_sched #(
   parameter int N      = 256,
   parameter int W      = 8,
   parameter int TO_CYC = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic         clr_all,
   output logic         grant_valid,
   output logic [W-1:0] grant_id,
   input  logic         grant_ack,
   output logic         timeout,
   output logic [N-1:0] pend,
   output logic         pend_any
);

   typedef enum logic [1:0] {IDLE, ENC, GRANT} state_t;

   localparam bit          TO_EN   = (TO_CYC != 0);
   localparam logic [15:0] TO_LAST = TO_EN ? 16'(TO_CYC - 1) : 16'd0;

   state_t         state_q, state_d;
   logic [N-1:0]   pend_q, pend_d;
   logic [N-1:0]   clr_vec, avail, grant_onehot;
   logic [W-1:0]   grant_id_q, grant_id_d;
   logic [W-1:0]   enc_q;
   logic           enc_v;
   logic [15:0]    cnt_q, cnt_d;
   logic           expire;

   assign avail        = pend_q & ~mask;
   assign grant_onehot = {{(N-1){1'b0}}, 1'b1} << grant_id_q;
   assign expire       = (state_q == GRANT) && !grant_ack && TO_EN && (cnt_q == TO_LAST);

   pe256_from_64 u_enc (
      .d (avail),
      .q (enc_q),
      .v (enc_v)
   );

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      cnt_d      = cnt_q;
      clr_vec    = '0;
      case (state_q)
         IDLE: begin
            if (|avail) state_d = ENC;
         end
         ENC: begin
            // A clr_all arriving in ENC would otherwise grant a bit that is being wiped this edge.
            if (enc_v && !clr_all) begin
               grant_id_d = enc_q;
               cnt_d      = 16'd0;
               state_d    = GRANT;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (grant_ack) begin
               clr_vec = grant_onehot;
               state_d = (|(avail & ~grant_onehot)) ? ENC : IDLE;
            end else if (expire) begin
               clr_vec = grant_onehot;
               state_d = IDLE;
            end else if (cnt_q != 16'hFFFF) begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clr_all) clr_vec = '1;
      pend_d = (pend_q & ~clr_vec) | req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pend_q     <= '0;
         grant_id_q <= '0;
         cnt_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         grant_id_q <= grant_id_d;
         cnt_q      <= cnt_d;
      end
   end

   assign grant_valid = (state_q == GRANT);
   assign grant_id    = grant_id_q;
   assign timeout     = expire;
   assign pend        = pend_q;
   assign pend_any    = |avail;

endmodule

// File: tb/tb_pe256_sched.sv
// Directed testbench for pe256_sched (TO_CYC = 4): reset, ordering, mask, timeout,
// clr_all and simultaneous-event cases with hand-computed expectations.

module tb_pe256_sched;

   logic         clk;
   logic         rst_n;
   logic [255:0] req;
   logic [255:0] mask;
   logic         clr_all;
   logic         grant_valid;
   logic [7:0]   grant_id;
   logic         grant_ack;
   logic         timeout;
   logic [255:0] pend;
   logic         pend_any;

   int checkCount;
   int errorCount;

   pe256_sched #(.N(256), .W(8), .TO_CYC(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .mask        (mask),
      .clr_all     (clr_all),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .grant_ack   (grant_ack),
      .timeout     (timeout),
      .pend        (pend),
      .pend_any    (pend_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] bitVec(input int idx);
      logic [255:0] one;
      one = 256'd1;
      return one << idx;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [255:0] reqV, input logic [255:0] maskV,
                                input logic ackV, input logic clrV);
      req       = reqV;
      mask      = maskV;
      grant_ack = ackV;
      clr_all   = clrV;
      #1;
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   // Each waitCycle() below is one rising edge; outputs are sampled 1-2 time units after it.
   initial begin
      checkCount = 0;
      errorCount = 0;
      rst_n = 1'b0;
      applyStimulus('1, '0, 1'b0, 1'b0);
      waitCycle();
      waitCycle();
      checkOutput("rst_grant_valid", grant_valid, 0);
      checkOutput("rst_grant_id", grant_id, 0);
      checkOutput("rst_timeout", timeout, 0);
      checkOutput("rst_pend", pend, 0);
      checkOutput("rst_pend_any", pend_any, 0);

      applyStimulus('0, '0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         waitCycle();
         checkOutput("idle_quiet", {pend_any, grant_valid}, 0);
      end

      // Single request at bit 200
      applyStimulus(bitVec(200), '0, 1'b0, 1'b0);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("single_pend", pend, bitVec(200));
      checkOutput("single_gv_k", grant_valid, 0);
      waitCycle();
      checkOutput("single_gv_k1", grant_valid, 0);
      waitCycle();
      checkOutput("single_gv_k2", grant_valid, 1);
      checkOutput("single_id", grant_id, 200);
      applyStimulus('0, '0, 1'b1, 1'b0);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("single_pend_clr", pend, 0);
      checkOutput("single_gv_drop", grant_valid, 0);
      waitCycle();
      checkOutput("single_idle", grant_valid, 0);

      // Ordering with ack held high
      applyStimulus(bitVec(5) | bitVec(123) | bitVec(200), '0, 1'b1, 1'b0);
      waitCycle();
      applyStimulus('0, '0, 1'b1, 1'b0);
      waitCycle();
      checkOutput("ord_gv_enc", grant_valid, 0);
      waitCycle();
      checkOutput("ord_gv1", grant_valid, 1);
      checkOutput("ord_id1", grant_id, 200);
      waitCycle();
      checkOutput("ord_gap1", grant_valid, 0);
      waitCycle();
      checkOutput("ord_gv2", grant_valid, 1);
      checkOutput("ord_id2", grant_id, 123);
      waitCycle();
      checkOutput("ord_gap2", grant_valid, 0);
      waitCycle();
      checkOutput("ord_gv3", grant_valid, 1);
      checkOutput("ord_id3", grant_id, 5);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("ord_pend_empty", pend, 0);
      checkOutput("ord_gv_end", grant_valid, 0);

      // Mask hides 255, so 7 goes first
      applyStimulus(bitVec(255) | bitVec(7), bitVec(255), 1'b0, 1'b0);
      waitCycle();
      applyStimulus('0, bitVec(255), 1'b0, 1'b0);
      waitCycle();
      waitCycle();
      checkOutput("mask_gv", grant_valid, 1);
      checkOutput("mask_id", grant_id, 7);
      applyStimulus('0, bitVec(255), 1'b1, 1'b0);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("mask_pend_kept", pend, bitVec(255));
      checkOutput("mask_pend_any", pend_any, 1);
      waitCycle();
      waitCycle();
      checkOutput("unmask_gv", grant_valid, 1);
      checkOutput("unmask_id", grant_id, 255);
      applyStimulus('0, '0, 1'b1, 1'b0);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("unmask_pend_clr", pend, 0);

      // Timeout after 4 GRANT cycles with no ack
      applyStimulus(bitVec(64), '0, 1'b0, 1'b0);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      waitCycle();
      waitCycle();
      checkOutput("to_gv", grant_valid, 1);
      for (int c = 1; c <= 3; c++) begin
         checkOutput("to_early", timeout, 0);
         waitCycle();
      end
      checkOutput("to_pulse", timeout, 1);
      checkOutput("to_pulse_gv", grant_valid, 1);
      checkOutput("to_id", grant_id, 64);
      waitCycle();
      checkOutput("to_after", timeout, 0);
      checkOutput("to_after_gv", grant_valid, 0);
      checkOutput("to_pend_clr", pend, 0);

      // clr_all together with req leaves only the new bit
      applyStimulus(bitVec(3) | bitVec(77), '1, 1'b0, 1'b0);
      waitCycle();
      applyStimulus(bitVec(9), '1, 1'b0, 1'b1);
      waitCycle();
      checkOutput("clr_keep_new", pend, bitVec(9));
      checkOutput("clr_gv", grant_valid, 0);
      applyStimulus('0, '1, 1'b0, 1'b1);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("clr_empty", pend, 0);

      // Re-request on the ack edge, then ack colliding with timeout
      applyStimulus(bitVec(200), '0, 1'b0, 1'b0);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      waitCycle();
      waitCycle();
      checkOutput("sim_gv", grant_valid, 1);
      applyStimulus(bitVec(200), '0, 1'b1, 1'b0);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("sim_repend", pend, bitVec(200));
      waitCycle();
      waitCycle();
      checkOutput("sim_regrant_gv", grant_valid, 1);
      checkOutput("sim_regrant_id", grant_id, 200);
      waitCycle();
      waitCycle();
      waitCycle();
      applyStimulus('0, '0, 1'b1, 1'b0);
      checkOutput("ackwin_no_to", timeout, 0);
      checkOutput("ackwin_gv", grant_valid, 1);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("ackwin_pend", pend, 0);
      checkOutput("ackwin_gv_drop", grant_valid, 0);

      // Asynchronous reset while a grant is offered
      applyStimulus(bitVec(123) | bitVec(4), '0, 1'b0, 1'b0);
      waitCycle();
      applyStimulus('0, '0, 1'b0, 1'b0);
      waitCycle();
      waitCycle();
      checkOutput("arst_pre_gv", grant_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_gv", grant_valid, 0);
      checkOutput("arst_pend", pend, 0);
      waitCycle();
      rst_n = 1'b1;
      waitCycle();
      checkOutput("arst_after", {pend_any, grant_valid}, 0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
